// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the FT232H synchronous-FIFO transmitter.
//   ft_tx_state_t : transmit FSM state encoding
//   FT_TX_DEPTH   : default transmit FIFO depth in bytes
//   ft_drives_bus : true in states where the FPGA owns adbus
package ft_pkg;

    localparam int FT_TX_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FLUSH = 2'd3
    } ft_tx_state_t;

    function automatic logic ft_drives_bus(input ft_tx_state_t st);
        return (st == ST_TURN) || (st == ST_WRITE);
    endfunction

endpackage

// File: rtl/ft_tx_fifo.sv
// ft_tx_fifo: synchronous DEPTH x 8 FIFO with first-word-fall-through head.
//   clk, rst      : clock, synchronous active-high reset (clears contents)
//   push, din     : write a byte (ignored when full)
//   pop           : drop the head byte (ignored when empty)
//   dout          : current head byte
//   full, empty   : occupancy flags
//   count         : number of stored bytes
module ft_tx_fifo
    import ft_pkg::*;
#(
    parameter int DEPTH = FT_TX_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr_r - rd_ptr_r;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == {(AW + 1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointers; contents are cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ft_tx.sv
// ft_tx: FT232H synchronous 245-FIFO transmit path (FPGA -> host).
//   clk, rst            : 60 MHz clkout domain, synchronous active-high reset
//   tx_valid/tx_data    : byte offered by the user, accepted when tx_ready
//   tx_ready            : FIFO has room (low while full or in reset)
//   flush               : request a send-immediate once pending bytes drain
//   txe_n               : FT232H has space (active-low)
//   wr_n, siwu_n        : FT232H write / send-immediate strobes (active-low)
//   adbus_out, adbus_oe : data for adbus and its output enable
//   busy                : FSM active, bytes queued or flush pending
//   tx_count            : bytes accepted by the FT232H, modulo 2^16
module ft_tx
    import ft_pkg::*;
#(
    parameter int DEPTH = FT_TX_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        flush,
    input  logic        txe_n,
    output logic        wr_n,
    output logic        siwu_n,
    output logic [7:0]  adbus_out,
    output logic        adbus_oe,
    output logic        busy,
    output logic [15:0] tx_count
);

    localparam int AW = $clog2(DEPTH);

    ft_tx_state_t state_r;
    ft_tx_state_t state_next_s;
    logic         push_s;
    logic         pop_s;
    logic         last_s;
    logic         full_s;
    logic         empty_s;
    logic [AW:0]  fifo_count_s;
    logic [7:0]   head_s;
    logic         pending_r;
    logic [15:0]  tx_count_r;
    logic         wr_n_r;
    logic         siwu_n_r;
    logic         oe_r;
    logic         wr_n_next_s;
    logic         siwu_n_next_s;
    logic         oe_next_s;

    ft_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (tx_data),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (fifo_count_s)
    );

    // No push-through: a full FIFO refuses even if the head leaves this cycle.
    assign tx_ready = !full_s && !rst;
    assign push_s   = tx_valid && tx_ready;
    // A byte is taken by the FT232H on each edge where wr_n is low and txe_n is low.
    assign pop_s    = (state_r == ST_WRITE) && !txe_n && !empty_s;
    assign last_s   = (fifo_count_s == {{AW{1'b0}}, 1'b1}) && !push_s;

    assign busy      = (state_r != ST_IDLE) || !empty_s || pending_r;
    assign tx_count  = tx_count_r;
    assign wr_n      = wr_n_r;
    assign siwu_n    = siwu_n_r;
    assign adbus_oe  = oe_r;
    assign adbus_out = head_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a flush waits until every queued byte has gone.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && !txe_n) begin
                    state_next_s = ST_TURN;
                end else if (pending_r && empty_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TURN:  state_next_s = ST_WRITE;
            ST_WRITE: begin
                if (txe_n) begin
                    state_next_s = ST_IDLE;
                end else if (last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_FLUSH: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Strobe decode from the next state so the registered strobes line up with state_r.
    always_comb begin
        wr_n_next_s   = 1'b1;
        siwu_n_next_s = 1'b1;
        oe_next_s     = ft_drives_bus(state_next_s);
        case (state_next_s)
            ST_WRITE: wr_n_next_s   = 1'b0;
            ST_FLUSH: siwu_n_next_s = 1'b0;
            default: begin
                wr_n_next_s   = 1'b1;
                siwu_n_next_s = 1'b1;
            end
        endcase
    end

    // Registered FT232H strobes and bus enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_n_r   <= 1'b1;
            siwu_n_r <= 1'b1;
            oe_r     <= 1'b0;
        end else begin
            wr_n_r   <= wr_n_next_s;
            siwu_n_r <= siwu_n_next_s;
            oe_r     <= oe_next_s;
        end
    end

    // Sticky flush request; a pulse during the FLUSH cycle re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (flush) begin
            pending_r <= 1'b1;
        end else if (state_r == ST_FLUSH) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Count of bytes accepted by the FT232H.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count_r <= 16'd0;
        end else if (pop_s) begin
            tx_count_r <= tx_count_r + 16'd1;
        end else begin
            tx_count_r <= tx_count_r;
        end
    end

endmodule

// File: tb/tb_ft_tx.sv
// tb_ft_tx: self-checking bench for ft_tx (DEPTH = 8).
module tb_ft_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        flush = 1'b0;
    logic        txe_n = 1'b1;
    logic        wr_n;
    logic        siwu_n;
    logic [7:0]  adbus_out;
    logic        adbus_oe;
    logic        busy;
    logic [15:0] tx_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Bytes seen accepted by the host side and SIWU strobes, sampled mid-cycle.
    logic [7:0] acc[$];
    int         siwu_lows = 0;
    int         siwu_at   = 0;

    ft_tx #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .flush     (flush),
        .txe_n     (txe_n),
        .wr_n      (wr_n),
        .siwu_n    (siwu_n),
        .adbus_out (adbus_out),
        .adbus_oe  (adbus_oe),
        .busy      (busy),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values hold at the next edge.
    always @(negedge clk) begin
        if (!rst && !wr_n && !txe_n) acc.push_back(adbus_out);
        if (!rst && !siwu_n) begin
            siwu_lows = siwu_lows + 1;
            siwu_at   = acc.size();
        end
    end

    typedef struct {
        logic        rst, valid;
        logic [7:0]  data;
        logic        flush, txe_n;
        logic        e_wr_n, e_oe, e_siwu, chk_ad;
        logic [7:0]  e_ad;
        logic        e_ready, e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(logic r, logic v, logic [7:0] d, logic f, logic t,
                                 logic w, logic oe, logic s, logic ca, logic [7:0] a,
                                 logic rdy, logic b, logic [15:0] c);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.flush = f; x.txe_n = t;
        x.e_wr_n = w; x.e_oe = oe; x.e_siwu = s; x.chk_ad = ca; x.e_ad = a;
        x.e_ready = rdy; x.e_busy = b; x.e_cnt = c;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tx_valid = 1'b0; flush = 1'b0;
        tick();
        chk("rst wr_n", {31'd0, wr_n}, 32'd1);
        chk("rst adbus_oe", {31'd0, adbus_oe}, 32'd0);
        chk("rst tx_count", {16'd0, tx_count}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst tx_ready", {31'd0, tx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("tx_ready after rst", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        tx_valid = 1'b1; tx_data = b; g = 0;
        while (!tx_ready && g < 50) begin tick(); g++; end
        if (g >= 50) chk("send timeout", 32'd1, 32'd0);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int g;
        g = 0;
        while (busy && g < bound) begin tick(); g++; end
        chk("wait idle timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_acc(input int n, input int bound);
        int g;
        g = 0;
        while (acc.size() < n && g < bound) begin tick(); g++; end
        chk("wait accept timeout", (acc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        int pushed;
        int g;

        // Basic burst then flush merge and re-arm (per-cycle expectations after each edge).
        vecs[0]  = mkv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mkv(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'd0);
        vecs[2]  = mkv(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 16'd0);
        vecs[3]  = mkv(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 16'd0);
        vecs[4]  = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 16'd1);
        vecs[5]  = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 16'd2);
        vecs[6]  = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd3);
        vecs[7]  = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3);
        vecs[8]  = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3);
        vecs[9]  = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd3);
        vecs[10] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd3);
        vecs[11] = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3);
        vecs[12] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3);
        vecs[13] = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3);
        vecs[14] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3);
        vecs[15] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd3);

        #2;
        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; tx_valid = vecs[i].valid; tx_data = vecs[i].data;
            flush = vecs[i].flush; txe_n = vecs[i].txe_n;
            tick();
            chk($sformatf("vec%0d wr_n", i), {31'd0, wr_n}, {31'd0, vecs[i].e_wr_n});
            chk($sformatf("vec%0d adbus_oe", i), {31'd0, adbus_oe}, {31'd0, vecs[i].e_oe});
            chk($sformatf("vec%0d siwu_n", i), {31'd0, siwu_n}, {31'd0, vecs[i].e_siwu});
            if (vecs[i].chk_ad)
                chk($sformatf("vec%0d adbus_out", i), {24'd0, adbus_out}, {24'd0, vecs[i].e_ad});
            chk($sformatf("vec%0d tx_ready", i), {31'd0, tx_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d tx_count", i), {16'd0, tx_count}, {16'd0, vecs[i].e_cnt});
        end
        flush = 1'b0;

        // Host back-pressure after two bytes; the held byte is resent after TURN.
        txe_n = 1'b1;
        do_reset();
        base = acc.size();
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
        txe_n = 1'b0;
        wait_acc(base + 2, 40);
        txe_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("stall%0d wr_n", c), {31'd0, wr_n}, 32'd1);
            chk($sformatf("stall%0d adbus_oe", c), {31'd0, adbus_oe}, 32'd0);
        end
        chk("stall accepted", acc.size() - base, 32'd2);
        txe_n = 1'b0;
        tick();
        chk("resume TURN oe", {31'd0, adbus_oe}, 32'd1);
        chk("resume TURN wr_n", {31'd0, wr_n}, 32'd1);
        chk("resume TURN data", {24'd0, adbus_out}, 32'hA2);
        wait_idle(40);
        chk("stall total", acc.size() - base, 32'd5);
        for (int i = 0; i < 5; i++)
            if (acc.size() > base + i)
                chk($sformatf("stall byte%0d", i), {24'd0, acc[base + i]}, 32'hA0 + i);
        chk("stall tx_count", {16'd0, tx_count}, 32'd5);

        // Full FIFO: ninth byte stalls until the first pop frees a slot.
        txe_n = 1'b1;
        do_reset();
        base = acc.size();
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 8'h50 + 8'(i);
            chk($sformatf("fill%0d tx_ready", i), {31'd0, tx_ready}, 32'd1);
            tick();
        end
        tx_data = 8'h58;
        chk("full tx_ready", {31'd0, tx_ready}, 32'd0);
        tick();
        chk("full stall tx_ready", {31'd0, tx_ready}, 32'd0);
        txe_n = 1'b0;
        tick();
        chk("full TURN tx_ready", {31'd0, tx_ready}, 32'd0);
        tick();
        chk("full WRITE tx_ready", {31'd0, tx_ready}, 32'd0);
        tick();
        chk("after pop tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("after pop accepted", acc.size() - base, 32'd1);
        tick();
        tx_valid = 1'b0;
        wait_idle(40);
        chk("full total", acc.size() - base, 32'd9);
        for (int i = 0; i < 9; i++)
            if (acc.size() > base + i)
                chk($sformatf("full byte%0d", i), {24'd0, acc[base + i]}, 32'h50 + i);
        chk("full tx_count", {16'd0, tx_count}, 32'd9);

        // Two flush pulses while bytes are queued merge into one SIWU after draining.
        txe_n = 1'b1;
        do_reset();
        base = acc.size();
        g = siwu_lows;
        send(8'h61);
        send(8'h62);
        flush = 1'b1; tick(); flush = 1'b0; tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush held while queued", siwu_lows - g, 32'd0);
        txe_n = 1'b0;
        wait_idle(40);
        repeat (4) tick();
        chk("flush bytes", acc.size() - base, 32'd2);
        if (acc.size() >= base + 2) begin
            chk("flush byte0", {24'd0, acc[base]}, 32'h61);
            chk("flush byte1", {24'd0, acc[base + 1]}, 32'h62);
        end
        chk("flush siwu count", siwu_lows - g, 32'd1);
        chk("flush siwu after drain", siwu_at - base, 32'd2);
        chk("flush busy", {31'd0, busy}, 32'd0);

        // Reset during the write of byte 2 of 4 discards the rest.
        txe_n = 1'b1;
        do_reset();
        base = acc.size();
        for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
        txe_n = 1'b0;
        wait_acc(base + 1, 40);
        chk("mid-burst data", {24'd0, adbus_out}, 32'hB1);
        chk("mid-burst wr_n", {31'd0, wr_n}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst wr_n", {31'd0, wr_n}, 32'd1);
        chk("midrst adbus_oe", {31'd0, adbus_oe}, 32'd0);
        chk("midrst tx_count", {16'd0, tx_count}, 32'd0);
        repeat (10) tick();
        chk("midrst no further bytes", acc.size() - base, 32'd1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst count stays", {16'd0, tx_count}, 32'd0);

        // 65537 streamed bytes: tx_count wraps to 1.
        txe_n = 1'b0;
        do_reset();
        base = acc.size();
        pushed = 0; g = 0;
        tx_valid = 1'b1;
        while (pushed < 65537 && g < 80000) begin
            tx_data = pushed[7:0];
            if (tx_ready) pushed++;
            tick();
            g++;
        end
        tx_valid = 1'b0;
        chk("stream pushes", pushed, 32'd65537);
        wait_idle(40);
        chk("stream accepted", acc.size() - base, 32'd65537);
        chk("stream tx_count wrap", {16'd0, tx_count}, 32'h0001);
        if (acc.size() >= base + 65537) begin
            chk("stream byte0", {24'd0, acc[base]}, 32'h00);
            chk("stream byte300", {24'd0, acc[base + 300]}, 32'h2C);
            chk("stream last", {24'd0, acc[base + 65536]}, 32'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ft_tx.md
FT_TX -- requirements
Module: ft_tx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the transmit FIFO depth in bytes (power of two, 2..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; it is the FT232H clkout (60 MHz) domain.
REQ-003 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port tx_valid, input, 1, meaning a byte is offered on tx_data.
REQ-005 The block SHALL have port tx_data, input, 8, the byte to send to the host.
REQ-006 The block SHALL have port tx_ready, output, 1, meaning the FIFO accepts a byte this cycle.
REQ-007 The block SHALL have port flush, input, 1, a one-cycle request for a send-immediate (SIWU) after pending bytes drain.
REQ-008 The block SHALL have port txe_n, input, 1, the FT232H "transmit FIFO has space" signal (active-low).
REQ-009 The block SHALL have port wr_n, output, 1, the FT232H write strobe (active-low).
REQ-010 The block SHALL have port siwu_n, output, 1, the FT232H send-immediate strobe (active-low).
REQ-011 The block SHALL have port adbus_out, output, 8, the data driven onto adbus.
REQ-012 The block SHALL have port adbus_oe, output, 1, meaning the FPGA drives adbus; the top-level tristate uses it.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE, or whenever the FIFO is non-empty or a flush is pending.
REQ-014 The block SHALL have port tx_count, output, 16, the count of bytes accepted by the FT232H, wrapping modulo 2^16.

Function
REQ-015 The block SHALL compute tx_ready = !full && !rst; a push SHALL occur on tx_valid && tx_ready.
REQ-016 The block SHALL keep tx_ready low when the FIFO is full, even if a pop happens in the same cycle (no push-through when full).
REQ-017 The FSM SHALL have four states: IDLE, TURN, WRITE and FLUSH.
REQ-018 IDLE: wr_n=1, siwu_n=1, adbus_oe=0; the FSM SHALL go to TURN when the FIFO is non-empty and txe_n=0, else to FLUSH when a flush is pending and the FIFO is empty.
REQ-019 TURN (one cycle, bus turnaround): adbus_oe=1, wr_n=1, adbus_out=FIFO head; the FSM SHALL go to WRITE unconditionally.
REQ-020 WRITE: adbus_oe=1, wr_n=0, adbus_out=FIFO head; at each clk edge with txe_n=0 the head SHALL be popped and tx_count incremented.
REQ-021 WRITE: at an edge where txe_n=1 the head SHALL NOT be popped, and the FSM SHALL go to IDLE; the same byte is re-sent on the next burst.
REQ-022 WRITE: when the pop empties the FIFO (last entry, no simultaneous push), the FSM SHALL go to IDLE.
REQ-023 WRITE: a push in the same cycle as the pop of the last entry SHALL keep the FSM in WRITE.
REQ-024 FLUSH: siwu_n=0 for exactly one cycle, adbus_oe=0; the pending flag SHALL be cleared and the FSM SHALL go to IDLE.
REQ-025 A flush pulse SHALL set a sticky pending flag; multiple pulses before service SHALL merge into one SIWU.
REQ-026 A flush pulse arriving in the FLUSH cycle itself SHALL set the flag again, giving one further SIWU.
REQ-027 Bytes SHALL leave in push order with no loss or duplication; adbus_out SHALL be registered or a direct FIFO-head read; wr_n, siwu_n and adbus_oe SHALL be registered.

Reset
REQ-028 While rst=1 at a clk edge, the block SHALL set: FSM=IDLE, FIFO empty, flush pending=0, wr_n=1, siwu_n=1, adbus_oe=0, adbus_out=0, tx_count=0, busy=0, tx_ready=0.
REQ-029 A reset asserted in the middle of a burst SHALL discard any unsent FIFO contents.
REQ-030 The block SHALL have tx_ready=1 in the first cycle after rst is deasserted.

Structure
REQ-031 Package ft_pkg SHALL hold the FSM state enum (ft_tx_state_t) and the default FIFO depth constant FT_TX_DEPTH.
REQ-032 The FIFO SHALL be a sub-module ft_tx_fifo (synchronous, DEPTH x 8, full/empty flags, read-head output); the FSM and counters SHALL stay in ft_tx.

Verification
REQ-033 The bench SHALL push 0x11,0x22,0x33 with txe_n=0 held -> states TURN, then 3 cycles with wr_n=0 showing 0x11,0x22,0x33 in order, then IDLE; tx_count=3.
REQ-034 The bench SHALL push 0xA0..0xA4 and raise txe_n after 2 bytes accepted, for 4 cycles -> wr_n=1 and adbus_oe=0 while txe_n=1; after txe_n=0 the bench SHALL see TURN then 0xA2,0xA3,0xA4; total tx_count=5 with no duplicates.
REQ-035 The bench SHALL push 9 bytes with txe_n=1 and DEPTH=8 -> tx_ready=0 after 8 pushes and byte 9 stalls; after txe_n=0, tx_ready=1 again only after a pop.
REQ-036 The bench SHALL push 2 bytes, pulse flush twice, txe_n=0 -> both bytes written, then exactly one siwu_n=0 cycle after the FIFO empties, then busy=0.
REQ-037 The bench SHALL assert rst for 1 cycle during the WRITE of byte 2 of 4 -> wr_n=1, adbus_oe=0 and tx_count=0 the next cycle; the remaining bytes are never driven.
REQ-038 The bench SHALL push 0xFFFF+2 bytes with txe_n=0 -> tx_count wraps to 0x0001.
